cmd_assembler: RTL and testbench
================================

Name: cmd_assembler

Overview:
Front-end command stage between the UART byte receiver and the register/control blocks (flags register, trigger, sampler).
Converts the SUMP host byte stream into commands:
- 1-byte short commands become single-cycle strobes.
- 5-byte long commands (opcode plus 32-bit little-endian payload) become one cmd_valid strobe with cmd_opcode/cmd_data.
- Downstream write enables are decoded from these outputs, e.g. flags write = cmd_valid && cmd_opcode==8'h82. The flags register consumes sc_finish_now as its finish_now input.

Parameters:
TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of a long command before it is abandoned (used only with CMD_TIMEOUT_EN; counter width = clog2(TIMEOUT_CYCLES)).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  single-cycle strobe, rx_data valid; may assert every cycle
rx_data  in  8  received byte
cmd_valid  out  1  one-cycle pulse, long command complete
cmd_opcode  out  8  opcode of last completed long command
cmd_data  out  32  payload of last completed long command
sc_reset  out  1  pulse, short opcode 8'h00
sc_arm  out  1  pulse, short opcode 8'h01
sc_id  out  1  pulse, short opcode 8'h02
sc_meta  out  1  pulse, short opcode 8'h04
sc_finish_now  out  1  pulse, short opcode 8'h05
busy  out  1  high while a long command is partially received
cmd_timeout  out  1  pulse, long command abandoned (constant 0 without CMD_TIMEOUT_EN)

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. All outputs registered.
- Reset values: all outputs 0, including cmd_opcode and cmd_data; state IDLE; byte count 0; shadow opcode/payload 0.
- Reset asserted mid-command discards the partial command. No pulse is emitted during or after reset.
- State IDLE, on rx_valid:
  - rx_data[7]==0 (short command): the matching sc_* pulses for exactly 1 cycle, the cycle after the byte is accepted (latency 1). Short opcodes other than 00/01/02/04/05 are ignored with no pulse. At most one sc_* is high in any cycle.
  - rx_data[7]==1 (long command): latch opcode into shadow, count=0, go to DATA. busy=1 from the next cycle.
- State DATA, on rx_valid:
  - Byte n (n=0..3) is written to shadow payload bits [8n+7:8n].
  - Every byte value, including 0x00 and values with bit7 set, is payload. No short-command decoding occurs in DATA.
- Completion on the 4th payload byte:
  - Next cycle: cmd_valid=1 for 1 cycle; cmd_opcode/cmd_data take the shadow values; busy=0; state IDLE.
  - cmd_opcode/cmd_data change only at completion and hold until the next completion. They are never partially updated.
- Back-to-back: a byte on the cycle after completion is decoded in IDLE. A 5-byte command sent on 5 consecutive cycles gives cmd_valid on cycle 6.
- Resync property: five consecutive 0x00 bytes always produce at least one sc_reset, whatever the starting state (any 0..4-byte partial command completes first).
- rx_valid low: state holds; no outputs pulse (except timeout, below).

Optional Feature:
Macro CMD_TIMEOUT_EN.
- Defined:
  - In DATA, a counter clears on each accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: state returns to IDLE, shadow is discarded, cmd_timeout pulses 1 cycle, busy drops the same cycle as the pulse, and cmd_opcode/cmd_data are unchanged.
  - A byte arriving on the timeout cycle takes priority; no timeout occurs.
- Undefined: no counter; DATA waits indefinitely; cmd_timeout tied 0.

Test Plan:
- Reset then bytes 82,78,56,34,12 on consecutive cycles -> cmd_valid single pulse on cycle 6; cmd_opcode=8'h82; cmd_data=32'h12345678; busy high cycles 2-5.
- Short bytes 01, 05, 02, 04, 03 -> sc_arm, sc_finish_now, sc_id, sc_meta one pulse each, 1 cycle after each byte; 03 produces no pulse; never two pulses together.
- Bytes C0,00,00 then 00,00,00,00,00 -> first two 00 complete long command (cmd_data=32'h0, opcode C0); remaining three 00 -> three sc_reset pulses.
- Long command 81,FF,80,01 with rst asserted before 4th byte, then 05 after release -> no cmd_valid; cmd_opcode/cmd_data=0; sc_finish_now pulses.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: bytes 82,AA then idle -> cmd_timeout pulse; busy falls; prior cmd_data unchanged; subsequent 82,01,00,00,00 -> cmd_data=32'h1.
- Payload bytes with bit7 set: 82,80,81,FF,C0 -> cmd_data=32'hC0FF8180; no short pulses and no new long-command start during payload.

Source files
------------

// File: rtl/cmd_assembler_if.sv
// +----------------------------------------------------------------------------+
// | cmd_assembler_if : byte-in / command-out bundle for cmd_assembler           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface cmd_assembler_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        sc_reset;
  logic        sc_arm;
  logic        sc_id;
  logic        sc_meta;
  logic        sc_finish_now;
  logic        busy;
  logic        cmd_timeout;

  // master: byte source / command consumer side
  modport master (
    output rx_valid, rx_data,
    input  cmd_valid, cmd_opcode, cmd_data, sc_reset, sc_arm, sc_id,
           sc_meta, sc_finish_now, busy, cmd_timeout
  );

  // slave: the assembler itself
  modport slave (
    input  rx_valid, rx_data,
    output cmd_valid, cmd_opcode, cmd_data, sc_reset, sc_arm, sc_id,
           sc_meta, sc_finish_now, busy, cmd_timeout
  );
endinterface

`default_nettype wire

// File: rtl/cmd_assembler.sv
// +----------------------------------------------------------------------------+
// | cmd_assembler : SUMP byte stream -> short-command strobes / long commands   |
// | Optional macro CMD_TIMEOUT_EN adds an inter-byte timeout in DATA state.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module cmd_assembler
`ifdef CMD_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1000000
)
`endif
(
  input wire             clk,
  input wire             rst,
  cmd_assembler_if.slave bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DATA = 1'b1} state_t;

  state_t      r_state,  w_state_nxt;
  logic [1:0]  r_cnt,    w_cnt_nxt;
  logic [7:0]  r_op,     w_op_nxt;
  logic [31:0] r_pay,    w_pay_nxt;
  logic        r_valid,  w_valid_nxt;
  logic [7:0]  r_opcode, w_opcode_nxt;
  logic [31:0] r_data,   w_data_nxt;
  logic [4:0]  r_sc,     w_sc_nxt;  // {finish_now, meta, id, arm, reset}
  logic        r_busy;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] c_TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic          r_to,   w_to_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_pay_nxt    = r_pay;
    w_valid_nxt  = 1'b0;
    w_opcode_nxt = r_opcode;
    w_data_nxt   = r_data;
    w_sc_nxt     = 5'b0;
`ifdef CMD_TIMEOUT_EN
    w_tcnt_nxt   = r_tcnt;
    w_to_nxt     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[7]) begin
            w_op_nxt    = bus.rx_data;
            w_cnt_nxt   = 2'd0;
            w_state_nxt = S_DATA;
`ifdef CMD_TIMEOUT_EN
            w_tcnt_nxt  = '0;
`endif
          end else begin
            case (bus.rx_data)
              8'h00:   w_sc_nxt = 5'b00001;
              8'h01:   w_sc_nxt = 5'b00010;
              8'h02:   w_sc_nxt = 5'b00100;
              8'h04:   w_sc_nxt = 5'b01000;
              8'h05:   w_sc_nxt = 5'b10000;
              default: w_sc_nxt = 5'b00000;
            endcase
          end
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          w_pay_nxt[{r_cnt, 3'b000} +: 8] = bus.rx_data;
          w_cnt_nxt = r_cnt + 2'd1;
`ifdef CMD_TIMEOUT_EN
          w_tcnt_nxt = '0;
`endif
          if (r_cnt == 2'd3) begin
            // Outputs are replaced atomically from the completed shadow
            w_valid_nxt  = 1'b1;
            w_opcode_nxt = r_op;
            w_data_nxt   = {bus.rx_data, r_pay[23:0]};
            w_state_nxt  = S_IDLE;
          end
        end
`ifdef CMD_TIMEOUT_EN
        else if (r_tcnt == c_TMAX) begin
          w_state_nxt = S_IDLE;
          w_to_nxt    = 1'b1;
          w_op_nxt    = 8'h00;
          w_pay_nxt   = 32'h0;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 2'd0;
      r_op     <= 8'h00;
      r_pay    <= 32'h0;
      r_valid  <= 1'b0;
      r_opcode <= 8'h00;
      r_data   <= 32'h0;
      r_sc     <= 5'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_pay    <= w_pay_nxt;
      r_valid  <= w_valid_nxt;
      r_opcode <= w_opcode_nxt;
      r_data   <= w_data_nxt;
      r_sc     <= w_sc_nxt;
      r_busy   <= (w_state_nxt == S_DATA);
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_to   <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_to   <= w_to_nxt;
    end
  end
  assign bus.cmd_timeout = r_to;
`else
  assign bus.cmd_timeout = 1'b0;
`endif

  assign bus.cmd_valid     = r_valid;
  assign bus.cmd_opcode    = r_opcode;
  assign bus.cmd_data      = r_data;
  assign bus.sc_reset      = r_sc[0];
  assign bus.sc_arm        = r_sc[1];
  assign bus.sc_id         = r_sc[2];
  assign bus.sc_meta       = r_sc[3];
  assign bus.sc_finish_now = r_sc[4];
  assign bus.busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cmd_assembler.sv
// +----------------------------------------------------------------------------+
// | tb_cmd_assembler : directed self-checking bench for cmd_assembler           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_cmd_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  cmd_assembler_if bus ();

`ifdef CMD_TIMEOUT_EN
  cmd_assembler #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`else
  cmd_assembler dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  // {finish_now, meta, id, arm, reset}
  function automatic logic [4:0] sc_vec();
    return {bus.sc_finish_now, bus.sc_meta, bus.sc_id, bus.sc_arm, bus.sc_reset};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one byte for one clock; returns 1ns after the accepting edge
  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] pl [4];
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {bus.cmd_valid, bus.busy, bus.cmd_timeout, sc_vec()}, 40'h0);
    chk("reset_opcode", bus.cmd_opcode, 40'h0);
    chk("reset_data", bus.cmd_data, 40'h0);
    rst = 1'b0;
    idle();

    // Long command 82 78 56 34 12 on consecutive cycles
    send(8'h82);
    chk("l1_busy_c2", {bus.busy, bus.cmd_valid}, 40'h2);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    chk("l1_busy_c5", {bus.busy, bus.cmd_valid}, 40'h2);
    send(8'h12);
    chk("l1_valid", {bus.busy, bus.cmd_valid}, 40'h1);
    chk("l1_opcode", bus.cmd_opcode, 40'h82);
    chk("l1_data", bus.cmd_data, 40'h12345678);
    idle();
    chk("l1_pulse_end", bus.cmd_valid, 40'h0);
    chk("l1_data_hold", bus.cmd_data, 40'h12345678);

    // Short commands
    send(8'h01);
    chk("sc_arm", sc_vec(), 40'h02);
    send(8'h05);
    chk("sc_finish", sc_vec(), 40'h10);
    send(8'h02);
    chk("sc_id", sc_vec(), 40'h04);
    send(8'h04);
    chk("sc_meta", sc_vec(), 40'h08);
    send(8'h03);
    chk("sc_03_none", sc_vec(), 40'h00);
    idle();
    chk("sc_idle_none", sc_vec(), 40'h00);

    // Resync: C0 00 00 00 00 completes a zero-payload command, then three resets
    send(8'hC0);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("rs_no_sc_payload", sc_vec(), 40'h00);
    send(8'h00);
    chk("rs_valid", {bus.cmd_valid, sc_vec()}, 40'h20);
    chk("rs_opcode", bus.cmd_opcode, 40'hC0);
    chk("rs_data", bus.cmd_data, 40'h0);
    send(8'h00);
    chk("rs_reset1", {bus.cmd_valid, sc_vec()}, 40'h01);
    send(8'h00);
    chk("rs_reset2", sc_vec(), 40'h01);
    send(8'h00);
    chk("rs_reset3", sc_vec(), 40'h01);

    // Reset mid-command discards the partial command
    send(8'h81);
    send(8'hFF);
    send(8'h80);
    send(8'h01);
    chk("mr_busy_before", bus.busy, 40'h1);
    #2 rst = 1'b1;
    #1;
    chk("mr_async_clear", {bus.busy, bus.cmd_valid, sc_vec()}, 40'h0);
    chk("mr_opcode", bus.cmd_opcode, 40'h0);
    idle();
    rst = 1'b0;
    idle();
    chk("mr_no_pulse", {bus.busy, bus.cmd_valid, sc_vec()}, 40'h0);
    send(8'h05);
    chk("mr_finish", {bus.cmd_valid, sc_vec()}, 40'h10);
    chk("mr_data_zero", bus.cmd_data, 40'h0);

    // Payload bytes with bit7 set are pure payload
    pl[0] = 8'h80; pl[1] = 8'h81; pl[2] = 8'hFF; pl[3] = 8'hC0;
    send(8'h82);
    for (int i = 0; i < 3; i++) begin
      send(pl[i]);
      chk("hp_payload_quiet", {bus.busy, bus.cmd_valid, sc_vec()}, 40'h40);
    end
    send(pl[3]);
    chk("hp_valid", {bus.busy, bus.cmd_valid}, 40'h1);
    chk("hp_opcode", bus.cmd_opcode, 40'h82);
    chk("hp_data", bus.cmd_data, 40'hC0FF8180);

`ifdef CMD_TIMEOUT_EN
    send(8'h82);
    send(8'hAA);
    repeat (15) idle();
    chk("to_not_yet", {bus.busy, bus.cmd_timeout}, 40'h2);
    idle();
    chk("to_pulse", {bus.busy, bus.cmd_timeout}, 40'h1);
    chk("to_data_kept", bus.cmd_data, 40'hC0FF8180);
    idle();
    chk("to_pulse_end", bus.cmd_timeout, 40'h0);
    send(8'h82);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("to_after_valid", bus.cmd_valid, 40'h1);
    chk("to_after_data", bus.cmd_data, 40'h1);
`else
    send(8'h82);
    send(8'hAA);
    repeat (40) idle();
    chk("nto_still_busy", {bus.busy, bus.cmd_timeout}, 40'h2);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    chk("nto_valid", bus.cmd_valid, 40'h1);
    chk("nto_data", bus.cmd_data, 40'h000001AA);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
